// File: rtl/mrna_iso_seq_pkg.sv
// Shared types and constants for the mRNA isolation valve sequencer.
// MRNAISO_SEQ_ABORT_EN adds the FLUSH state used by the abort path.
package mrna_iso_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_LYSE    = 3'd2,
        ST_BEADS   = 3'd3,
        ST_MIX     = 3'd4,
        ST_SEP     = 3'd5,
`ifdef MRNAISO_SEQ_ABORT_EN
        ST_COLLECT = 3'd6,
        ST_FLUSH   = 3'd7
`else
        ST_COLLECT = 3'd6
`endif
    } state_t;

    // Bit positions in valve_ctl; a 1 pressurizes the line and closes the valve
    localparam int V_CELLS_IN    = 0;
    localparam int V_CELLS_OUT   = 1;
    localparam int V_COLLECT     = 2;
    localparam int V_LYSIS_IN    = 3;
    localparam int V_LYSIS_WASTE = 4;
    localparam int V_BEADS_IN    = 5;
    localparam int V_BEAD_WASTE  = 6;
    localparam int V_PUSH        = 7;
    localparam int V_SEP         = 8;
    localparam int V_SIEVE       = 9;
    localparam int V_WASTE       = 10;
    localparam int V_SPARE       = 11;

    localparam logic [11:0] VALVE_ALL_CLOSED = 12'hFFF;

    localparam logic [2:0] PUMP_IDLE = 3'b111;
    localparam logic [2:0] PUMP_PH0  = 3'b110;
    localparam logic [2:0] PUMP_PH1  = 3'b101;
    localparam logic [2:0] PUMP_PH2  = 3'b011;

endpackage

// File: rtl/mrna_iso_pump_phaser.sv
// Three-phase peristaltic pump pattern generator with a PUMP_DIV prescaler.
// Phase pattern is registered; stroke_done flags the last cycle of each stroke.
module mrna_iso_pump_phaser
    import mrna_iso_seq_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int PUMP_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [2:0] phase_pat,
    output logic       stroke_done
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(PUMP_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_cnt_nxt;
    logic [1:0]       ph;
    logic [1:0]       ph_nxt;
    logic             run;
    logic             phase_end;

    function automatic logic [2:0] pat_of(input logic [1:0] p);
        logic [2:0] r;
        r = PUMP_PH0;
        case (p)
            2'd1:    r = PUMP_PH1;
            2'd2:    r = PUMP_PH2;
            default: r = PUMP_PH0;
        endcase
        return r;
    endfunction

    // en reflects the state of the coming cycle, run that of the current one
    assign phase_end   = run && (div_cnt == DIV_LAST);
    assign stroke_done = phase_end && (ph == 2'd2);

    always_comb begin
        div_cnt_nxt = '0;
        ph_nxt      = 2'd0;
        if (en && run) begin
            if (phase_end) begin
                ph_nxt = (ph == 2'd2) ? 2'd0 : ph + 2'd1;
            end else begin
                div_cnt_nxt = div_cnt + CNT_W'(1);
                ph_nxt      = ph;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            ph        <= 2'd0;
            run       <= 1'b0;
            phase_pat <= PUMP_IDLE;
        end else begin
            div_cnt   <= div_cnt_nxt;
            ph        <= ph_nxt;
            run       <= en;
            phase_pat <= en ? pat_of(ph_nxt) : PUMP_IDLE;
        end
    end

endmodule

// File: rtl/mrna_iso_valve_sequencer.sv
// Run sequencer for the three-lane mRNA isolation chip: FSM, dwell/stroke counters, valve decode.
// Define MRNAISO_SEQ_ABORT_EN to add the abort input, aborted pulse and FLUSH state.
module mrna_iso_valve_sequencer
    import mrna_iso_seq_pkg::*;
#(
    parameter int TMR_W    = 16,
    parameter int PUMP_DIV = 1000,
    parameter int T_LOAD   = 100,
    parameter int T_LYSE   = 100,
    parameter int T_BEAD   = 100,
    parameter int N_MIX    = 10,
    parameter int T_SEP    = 100,
`ifdef MRNAISO_SEQ_ABORT_EN
    parameter int T_COLL   = 100,
    parameter int T_FLUSH  = 100
`else
    parameter int T_COLL   = 100
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef MRNAISO_SEQ_ABORT_EN
    input  logic        abort,
    output logic        aborted,
`endif
    output logic        busy,
    output logic        done,
    output logic [2:0]  state_o,
    output logic [11:0] valve_ctl,
    output logic [2:0]  pump
);

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] dwell;
    logic [TMR_W-1:0] strokes;
    logic             stroke_done;
    logic             mix_next;

    function automatic logic [TMR_W-1:0] dwell_load(input state_t s);
        logic [TMR_W-1:0] d;
        d = '0;
        case (s)
            ST_LOAD:    d = TMR_W'(T_LOAD - 1);
            ST_LYSE:    d = TMR_W'(T_LYSE - 1);
            ST_BEADS:   d = TMR_W'(T_BEAD - 1);
            ST_SEP:     d = TMR_W'(T_SEP - 1);
            ST_COLLECT: d = TMR_W'(T_COLL - 1);
`ifdef MRNAISO_SEQ_ABORT_EN
            ST_FLUSH:   d = TMR_W'(T_FLUSH - 1);
`endif
            default:    d = '0;
        endcase
        return d;
    endfunction

    function automatic logic [11:0] valve_decode(input state_t s);
        logic [11:0] v;
        v = VALVE_ALL_CLOSED;
        case (s)
            ST_LOAD: begin
                v[V_CELLS_IN]  = 1'b0;
                v[V_CELLS_OUT] = 1'b0;
            end
            ST_LYSE: begin
                v[V_LYSIS_IN]    = 1'b0;
                v[V_LYSIS_WASTE] = 1'b0;
            end
            ST_BEADS: begin
                v[V_BEADS_IN]   = 1'b0;
                v[V_BEAD_WASTE] = 1'b0;
            end
            // Sieve stays closed in SEP so the beads are trapped
            ST_SEP: begin
                v[V_SEP]   = 1'b0;
                v[V_PUSH]  = 1'b0;
                v[V_WASTE] = 1'b0;
            end
            ST_COLLECT: begin
                v[V_SIEVE]   = 1'b0;
                v[V_COLLECT] = 1'b0;
                v[V_PUSH]    = 1'b0;
            end
`ifdef MRNAISO_SEQ_ABORT_EN
            ST_FLUSH: begin
                v[V_WASTE]       = 1'b0;
                v[V_LYSIS_WASTE] = 1'b0;
                v[V_BEAD_WASTE]  = 1'b0;
            end
`endif
            default: v = VALVE_ALL_CLOSED;
        endcase
        return v;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start)        state_nxt = ST_LOAD;
            ST_LOAD:    if (dwell == '0)  state_nxt = ST_LYSE;
            ST_LYSE:    if (dwell == '0)  state_nxt = ST_BEADS;
            ST_BEADS:   if (dwell == '0)  state_nxt = ST_MIX;
            ST_MIX:     if (stroke_done && strokes == '0) state_nxt = ST_SEP;
            ST_SEP:     if (dwell == '0)  state_nxt = ST_COLLECT;
            ST_COLLECT: if (dwell == '0)  state_nxt = ST_IDLE;
`ifdef MRNAISO_SEQ_ABORT_EN
            ST_FLUSH:   if (dwell == '0)  state_nxt = ST_IDLE;
`endif
            default:    state_nxt = ST_IDLE;
        endcase
`ifdef MRNAISO_SEQ_ABORT_EN
        // Abort overrides every busy transition, including COLLECT completion
        if (abort && state != ST_IDLE && state != ST_FLUSH) begin
            state_nxt = ST_FLUSH;
        end
`endif
    end

    assign mix_next = (state_nxt == ST_MIX);

    mrna_iso_pump_phaser #(
        .CNT_W    (TMR_W),
        .PUMP_DIV (PUMP_DIV)
    ) u_phaser (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (mix_next),
        .phase_pat   (pump),
        .stroke_done (stroke_done)
    );

    // Outputs are decoded from the next state so they change on the same edge as state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dwell     <= '0;
            strokes   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valve_ctl <= VALVE_ALL_CLOSED;
`ifdef MRNAISO_SEQ_ABORT_EN
            aborted   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != ST_IDLE);
            done      <= (state == ST_COLLECT) && (state_nxt == ST_IDLE);
            valve_ctl <= valve_decode(state_nxt);
`ifdef MRNAISO_SEQ_ABORT_EN
            aborted   <= (state == ST_FLUSH) && (state_nxt == ST_IDLE);
`endif
            if (state_nxt != state) begin
                dwell <= dwell_load(state_nxt);
            end else if (dwell != '0) begin
                dwell <= dwell - TMR_W'(1);
            end
            if (mix_next && state != ST_MIX) begin
                strokes <= TMR_W'(N_MIX - 1);
            end else if (state == ST_MIX && stroke_done && strokes != '0) begin
                strokes <= strokes - TMR_W'(1);
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_mrna_iso_valve_sequencer.sv
// Bench for mrna_iso_valve_sequencer: directed and random start/abort against a run-position model.
module tb_mrna_iso_valve_sequencer;

    localparam int TD      = 4;
    localparam int PD      = 2;
    localparam int NM      = 2;
    localparam int TF      = 3;
    localparam int MIX_LEN = 3 * PD * NM;
    localparam int RUN_LEN = 5 * TD + MIX_LEN;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [2:0]  state_o;
    logic [11:0] valve_ctl;
    logic [2:0]  pump;
`ifdef MRNAISO_SEQ_ABORT_EN
    logic        aborted;
`endif

    int   errors = 0;
    int   checks = 0;
    int   pos    = -1;
    int   flush  = 0;
    logic exp_done = 1'b0;
    logic exp_ab   = 1'b0;

    always #5 clk = ~clk;

    mrna_iso_valve_sequencer #(
        .TMR_W    (16),
        .PUMP_DIV (PD),
        .T_LOAD   (TD),
        .T_LYSE   (TD),
        .T_BEAD   (TD),
        .N_MIX    (NM),
        .T_SEP    (TD),
`ifdef MRNAISO_SEQ_ABORT_EN
        .T_COLL   (TD),
        .T_FLUSH  (TF)
`else
        .T_COLL   (TD)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef MRNAISO_SEQ_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .busy      (busy),
        .done      (done),
        .state_o   (state_o),
        .valve_ctl (valve_ctl),
        .pump      (pump)
    );

    function automatic int exp_state();
        if (flush > 0)               return 7;
        if (pos < 0)                 return 0;
        if (pos < TD)                return 1;
        if (pos < 2*TD)              return 2;
        if (pos < 3*TD)              return 3;
        if (pos < 3*TD + MIX_LEN)    return 4;
        if (pos < 4*TD + MIX_LEN)    return 5;
        return 6;
    endfunction

    function automatic logic [11:0] exp_valve(input int s);
        logic [11:0] v;
        v = 12'hFFF;
        case (s)
            1: begin v[0] = 1'b0; v[1] = 1'b0; end
            2: begin v[3] = 1'b0; v[4] = 1'b0; end
            3: begin v[5] = 1'b0; v[6] = 1'b0; end
            5: begin v[8] = 1'b0; v[7] = 1'b0; v[10] = 1'b0; end
            6: begin v[9] = 1'b0; v[2] = 1'b0; v[7] = 1'b0; end
            7: begin v[10] = 1'b0; v[4] = 1'b0; v[6] = 1'b0; end
            default: v = 12'hFFF;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] exp_pump();
        int ph;
        if (exp_state() != 4) return 3'b111;
        ph = ((pos - 3*TD) / PD) % 3;
        return 3'b111 & ~(3'b001 << ph);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int s;
        s = exp_state();
        chk("state_o",   16'(state_o),   16'(s));
        chk("busy",      16'(busy),      16'(s != 0));
        chk("done",      16'(done),      16'(exp_done));
        chk("valve_ctl", 16'(valve_ctl), 16'(exp_valve(s)));
        chk("pump",      16'(pump),      16'(exp_pump()));
`ifdef MRNAISO_SEQ_ABORT_EN
        chk("aborted",   16'(aborted),   16'(exp_ab));
`endif
    endtask

    task automatic model_update(input logic st, input logic ab);
        logic ab_on;
        ab_on = ab;
`ifndef MRNAISO_SEQ_ABORT_EN
        ab_on = 1'b0;
`endif
        exp_done = 1'b0;
        exp_ab   = 1'b0;
        if (flush > 0) begin
            flush--;
            if (flush == 0) begin
                pos    = -1;
                exp_ab = 1'b1;
            end
        end else if (pos >= 0 && ab_on) begin
            flush = TF;
        end else if (pos < 0) begin
            if (st) pos = 0;
        end else begin
            pos++;
            if (pos == RUN_LEN) begin
                pos      = -1;
                exp_done = 1'b1;
            end
        end
    endtask

    task automatic step(input logic st, input logic ab);
        start = st;
        abort = ab;
        @(posedge clk);
        model_update(st, ab);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // single pulsed run, then idle
        step(1'b1, 1'b0);
        repeat (40) step(1'b0, 1'b0);

        // start held high: back-to-back runs
        repeat (70) step(1'b1, 1'b0);
        repeat (40) step(1'b0, 1'b0);

        // start pulsed again during LYSE
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b0);

        repeat (400) step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
        repeat (45) step(1'b0, 1'b0);

        // asynchronous reset between edges in the middle of MIX
        step(1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        pos      = -1;
        flush    = 0;
        exp_done = 1'b0;
        exp_ab   = 1'b0;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (34) step(1'b0, 1'b0);

`ifdef MRNAISO_SEQ_ABORT_EN
        // abort in first BEADS cycle, then abort in IDLE, then abort on last COLLECT cycle
        step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (31) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
